// File: rtl/fb_pkg.sv
// Shared types for the frame-buffer reader.
//   fb_state_e : reader state machine encoding (IDLE / RUN / DRAIN)
//   fb_tag_t   : per-pixel framing tags carried alongside the pixel data
package fb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } fb_state_e;

  typedef struct packed {
    logic sof;
    logic eol;
    logic eof;
  } fb_tag_t;

  localparam int FB_TAG_W = $bits(fb_tag_t);

endpackage

// File: rtl/frame_buffer_reader_if.sv
// Pixel output stream of the frame-buffer reader.
//   m_valid_o / m_ready_i : valid/ready handshake
//   m_data_o              : pixel
//   m_sof_o/m_eol_o/m_eof_o : framing tags, qualified by m_valid_o
// master = pixel source (reader), slave = pixel sink.
interface frame_buffer_reader_if #(
  parameter int DATA_WIDTH = 8
) ();

  logic                  m_valid_o;
  logic                  m_ready_i;
  logic [DATA_WIDTH-1:0] m_data_o;
  logic                  m_sof_o;
  logic                  m_eol_o;
  logic                  m_eof_o;

  modport master (
    output m_valid_o, m_data_o, m_sof_o, m_eol_o, m_eof_o,
    input  m_ready_i
  );

  modport slave (
    input  m_valid_o, m_data_o, m_sof_o, m_eol_o, m_eof_o,
    output m_ready_i
  );

endinterface

// File: rtl/pixel_skid_fifo.sv
// Two-entry FIFO holding returned pixels (data + tags) until the sink
// accepts them.
//   clk_i, rst_ni : clock, async active-low reset
//   push_i/push_data_i : write one entry
//   pop_i         : consume the head entry
//   head_o        : current head entry (stable until popped)
//   empty_o, count_o : occupancy
module pixel_skid_fifo #(
  parameter int WIDTH = 11
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             empty_o,
  output logic [1:0]       count_o
);

  logic [1:0][WIDTH-1:0] mem_q;
  logic                  wr_ptr_q, rd_ptr_q;
  logic [1:0]            count_q;
  logic                  do_push, do_pop;

  assign do_pop  = pop_i && (count_q != 2'd0);
  // A full FIFO may still accept a write when the head leaves in the same cycle.
  assign do_push = push_i && ((count_q != 2'd2) || do_pop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q    <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign empty_o = (count_q == 2'd0);
  assign count_o = count_q;

endmodule

// File: rtl/frame_buffer_reader.sv
// Reads one frame out of a synchronous RAM in raster order and streams it
// as tagged pixels.
//   clk_i, rst_ni          : clock, async active-low reset
//   start_i                : frame request, honoured only while idle
//   rd_en_o, rd_address_o  : RAM read port (data returns one cycle later)
//   rd_data_i              : RAM read data
//   m_if (master)          : pixel stream with sof/eol/eof tags
//   busy_o                 : frame in progress
//   done_o                 : one-cycle pulse when the last pixel has left
module frame_buffer_reader
  import fb_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int H_PIXELS   = 16,
  parameter int V_PIXELS   = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  output logic                  rd_en_o,
  output logic [ADDR_WIDTH-1:0] rd_address_o,
  input  logic [DATA_WIDTH-1:0] rd_data_i,
  frame_buffer_reader_if.master m_if,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int PW = DATA_WIDTH + FB_TAG_W;
  localparam logic [ADDR_WIDTH-1:0] X_LAST = ADDR_WIDTH'(H_PIXELS - 1);
  localparam logic [ADDR_WIDTH-1:0] A_LAST = ADDR_WIDTH'(H_PIXELS * V_PIXELS - 1);

  fb_state_e             state_q;
  logic [ADDR_WIDTH-1:0] addr_q, x_q, y_q, last_addr_q;
  logic                  inflight_q;
  fb_tag_t               tag_q, tag_now;
  logic                  issue, xfer, fifo_empty;
  logic [1:0]            fifo_count;
  logic [PW-1:0]         head;

  assign xfer = m_if.m_valid_o && m_if.m_ready_i;

  // Keep at most two pixels committed (queued + in flight) so the FIFO can
  // never overflow; a pop in the same cycle frees a slot for a new read.
  assign issue = (state_q == ST_RUN) &&
                 ((({1'b0, fifo_count} + {2'b00, inflight_q}) < 3'd2) || xfer);

  assign tag_now.sof = (x_q == '0) && (y_q == '0);
  assign tag_now.eol = (x_q == X_LAST);
  assign tag_now.eof = (addr_q == A_LAST);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      x_q         <= '0;
      y_q         <= '0;
      last_addr_q <= '0;
      inflight_q  <= 1'b0;
      tag_q       <= '0;
    end else begin
      inflight_q <= issue;
      if (issue) begin
        tag_q       <= tag_now;
        last_addr_q <= addr_q;
        addr_q      <= addr_q + 1'b1;
        if (x_q == X_LAST) begin
          x_q <= '0;
          y_q <= y_q + 1'b1;
        end else begin
          x_q <= x_q + 1'b1;
        end
      end
      unique case (state_q)
        ST_IDLE: if (start_i) begin
          state_q <= ST_RUN;
          addr_q  <= '0;
          x_q     <= '0;
          y_q     <= '0;
        end
        ST_RUN:   if (issue && tag_now.eof) state_q <= ST_DRAIN;
        ST_DRAIN: if (fifo_empty && !inflight_q) state_q <= ST_IDLE;
        default:  state_q <= ST_IDLE;
      endcase
    end
  end

  // Returned data lands in the FIFO one edge after its issue cycle, paired
  // with the tags computed when the address went out.
  pixel_skid_fifo #(.WIDTH(PW)) u_fifo (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .push_i      (inflight_q),
    .push_data_i ({tag_q, rd_data_i}),
    .pop_i       (xfer),
    .head_o      (head),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  assign m_if.m_valid_o = !fifo_empty;
  assign m_if.m_data_o  = head[DATA_WIDTH-1:0];
  assign m_if.m_sof_o   = head[DATA_WIDTH+2];
  assign m_if.m_eol_o   = head[DATA_WIDTH+1];
  assign m_if.m_eof_o   = head[DATA_WIDTH];

  // Address is only driven fresh on an issue; otherwise the last issued
  // address is held so the RAM port stays quiet.
  assign rd_en_o      = issue;
  assign rd_address_o = issue ? addr_q : last_addr_q;

  assign busy_o = (state_q != ST_IDLE);
  assign done_o = (state_q == ST_DRAIN) && fifo_empty && !inflight_q;

endmodule
